// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl
// Boot/run sequencer that sits in front of the cpu. It takes a memory image
// as a stream of words and writes it through the cpu external load ports:
// dmem words first, then imem words. It then raises the cpu enable. While the
// cpu runs, it watches the fetched instruction for the STOP opcode. When STOP
// is seen it freezes the cpu and reports the run length and the test id.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        begin a load+run; only honoured in IDLE or DONE
//   img_valid    image word valid
//   img_data     image word (imem phase uses [31:0])
//   img_ready    image word accepted on img_valid & img_ready
//   instruction  cpu fetched instruction (probe)
//   enable       cpu enable
//   addr_ext     imem load address     wen_ext    imem write strobe
//   ren_ext      imem read strobe (0)  wdata_ext  imem write data
//   addr_ext_2   dmem load address     wen_ext_2  dmem write strobe
//   ren_ext_2    dmem read strobe (0)  wdata_ext_2 dmem write data
//   busy         high in LOAD_D/LOAD_I/GAP/RUN
//   done         high in DONE
//   test_id      instruction[31:28] captured at STOP
//   cycle_count  RUN cycles counted before STOP; saturates at all-ones
module cpu_boot_ctrl #(
  parameter int             DMEM_WORDS  = 128,
  parameter int             IMEM_WORDS  = 128,
  parameter logic [6:0]     STOP_OPCODE = 7'b1111110,
  parameter int             CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             img_valid,
  input  logic [63:0]      img_data,
  output logic             img_ready,
  input  logic [31:0]      instruction,
  output logic             enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic [3:0]       test_id,
  output logic [CNT_W-1:0] cycle_count
);

  // One spare bit keeps the index wide enough even for single-word images.
  localparam int IDX_W = $clog2((DMEM_WORDS > IMEM_WORDS) ? DMEM_WORDS : IMEM_WORDS) + 1;
  localparam logic [IDX_W-1:0] DMEM_LAST = IDX_W'(DMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_LOAD_I = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             stop_seen;
  logic             unused_instr_bits;

  assign img_ready = (state == S_LOAD_D) || (state == S_LOAD_I);
  assign busy      = img_ready || (state == S_GAP) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;

  assign accept    = img_valid && img_ready;
  assign stop_seen = (instruction[6:0] == STOP_OPCODE);

  // Only the opcode and test-id fields of the probe matter here.
  assign unused_instr_bits = ^instruction[27:7];

  // NOTE: all state is updated with non-blocking assignments so that every
  // register samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      enable      <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      test_id     <= '0;
      cycle_count <= '0;
    end else begin
      // The write strobes are single-cycle pulses. Address and data hold
      // between accepts within their own load phase. They fall to zero once
      // the registered write that ends the phase has issued.
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      if (state != S_LOAD_D) begin
        addr_ext_2  <= '0;
        wdata_ext_2 <= '0;
      end
      if (state != S_LOAD_I) begin
        addr_ext  <= '0;
        wdata_ext <= '0;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD_D;
            idx         <= '0;
            cycle_count <= '0;
          end
        end

        S_LOAD_D: begin
          if (accept) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= 64'(idx) << 3;
            wdata_ext_2 <= img_data;
            if (idx == DMEM_LAST) begin
              state <= S_LOAD_I;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_LOAD_I: begin
          if (accept) begin
            wen_ext   <= 1'b1;
            addr_ext  <= 64'(idx) << 2;
            wdata_ext <= img_data[31:0];
            if (idx == IMEM_LAST) begin
              state <= S_GAP;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // The last imem write lands during GAP. The cpu is enabled only after it.
        S_GAP: begin
          state       <= S_RUN;
          enable      <= 1'b1;
          cycle_count <= '0;
        end

        S_RUN: begin
          if (stop_seen) begin
            // The STOP cycle itself is not counted.
            test_id <= instruction[31:28];
            enable  <= 1'b0;
            state   <= S_DONE;
          end else if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl
// Directed bench for cpu_boot_ctrl. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the rising edge.
module tb_cpu_boot_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] STOP = 32'h4000_007E;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        img_valid;
  logic [63:0] img_data;
  logic        img_ready;
  logic [31:0] instruction;
  logic        enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        busy;
  logic        done;
  logic [3:0]  test_id;
  logic [31:0] cycle_count;

  int vectors    = 0;
  int miscompares = 0;

  cpu_boot_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .img_valid   (img_valid),
    .img_data    (img_data),
    .img_ready   (img_ready),
    .instruction (instruction),
    .enable      (enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .busy        (busy),
    .done        (done),
    .test_id     (test_id),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dword(input int i);
    return {16'hC0DE, 48'(i)};
  endfunction

  // Offers dmem word i with valid high. Then checks the registered write one cycle later.
  task automatic dmem_word(input int i);
    img_valid = 1'b1;
    img_data  = dword(i);
    @(negedge clk);
    check("dmem_wen",   64'(wen_ext_2), 64'd1);
    check("dmem_addr",  addr_ext_2, 64'(i) * 64'd8);
    check("dmem_wdata", wdata_ext_2, dword(i));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(img_ready), 64'd0);
    check({tag, "_en"},    64'(enable),    64'd0);
    check({tag, "_wen"},   64'(wen_ext),   64'd0);
    check({tag, "_wen2"},  64'(wen_ext_2), 64'd0);
    check({tag, "_addr"},  addr_ext,       64'd0);
    check({tag, "_addr2"}, addr_ext_2,     64'd0);
    check({tag, "_wd"},    64'(wdata_ext), 64'd0);
    check({tag, "_wd2"},   wdata_ext_2,    64'd0);
    check({tag, "_ren"},   64'({ren_ext, ren_ext_2}), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_tid"},   64'(test_id),   64'd0);
    check({tag, "_cnt"},   64'(cycle_count), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    img_valid   = 1'b0;
    img_data    = '0;
    instruction = NOP;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // img_valid in IDLE is ignored.
    img_valid = 1'b1;
    img_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("idle_ready", 64'(img_ready), 64'd0);
    check("idle_wen2",  64'(wen_ext_2), 64'd0);
    check("idle_busy",  64'(busy),      64'd0);
    img_valid = 1'b0;

    // Start; LOAD_D is entered on the next edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("loadd_ready", 64'(img_ready), 64'd1);
    check("loadd_busy",  64'(busy),      64'd1);

    // Full dmem image with valid every cycle. The STOP pattern is present
    // during the load and must be ignored.
    instruction = STOP;
    for (int i = 0; i < 128; i++) dmem_word(i);
    check("loadi_ready", 64'(img_ready), 64'd1);
    check("loadi_en",    64'(enable),    64'd0);

    // imem image with valid toggling 0/1.
    for (int j = 0; j < 128; j++) begin
      img_valid = 1'b0;
      img_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      check("imem_idle_wen",  64'(wen_ext),   64'd0);
      check("imem_idle_wen2", 64'(wen_ext_2), 64'd0);
      check("imem_idle_done", 64'(done),      64'd0);
      img_valid = 1'b1;
      img_data  = {32'hDEAD_BEEF, 32'h1000_0000 + 32'(j)};
      @(negedge clk);
      check("imem_wen",   64'(wen_ext),   64'd1);
      check("imem_addr",  addr_ext,       64'(j) * 64'd4);
      check("imem_wdata", 64'(wdata_ext), 64'h1000_0000 + 64'(j));
    end
    // Now in GAP: the last imem write is visible here.
    img_valid   = 1'b0;
    instruction = NOP;
    check("gap_ready", 64'(img_ready), 64'd0);
    check("gap_busy",  64'(busy),      64'd1);
    check("gap_en",    64'(enable),    64'd0);

    // First RUN cycle.
    @(negedge clk);
    check("run_en",    64'(enable),      64'd1);
    check("run_cnt0",  64'(cycle_count), 64'd0);
    check("run_wen",   64'(wen_ext),     64'd0);
    check("run_addr",  addr_ext,         64'd0);
    check("run_wdata", 64'(wdata_ext),   64'd0);

    // 20 NOP cycles with a start pulse that must be ignored.
    for (int k = 1; k <= 20; k++) begin
      start = (k == 5);
      @(negedge clk);
      check("run_cnt",  64'(cycle_count), 64'(k));
      check("run_en_k", 64'(enable),      64'd1);
      check("run_busy", 64'(busy),        64'd1);
    end
    start = 1'b0;

    // STOP: enable drops, done rises, and the count holds at 20.
    instruction = STOP;
    @(negedge clk);
    instruction = NOP;
    check("stop_done", 64'(done),        64'd1);
    check("stop_en",   64'(enable),      64'd0);
    check("stop_cnt",  64'(cycle_count), 64'd20);
    check("stop_tid",  64'(test_id),     64'd4);
    check("stop_busy", 64'(busy),        64'd0);
    repeat (3) @(negedge clk);
    check("done_hold",     64'(done),        64'd1);
    check("done_cnt_hold", 64'(cycle_count), 64'd20);

    // Restart from DONE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done",  64'(done),        64'd0);
    check("restart_ready", 64'(img_ready),   64'd1);
    check("restart_cnt",   64'(cycle_count), 64'd0);
    for (int i = 0; i < 50; i++) dmem_word(i);

    // Reset while word idx 50 is being offered.
    rst       = 1'b1;
    img_valid = 1'b1;
    img_data  = dword(50);
    @(negedge clk);
    check_all_zero("midrst");
    rst       = 1'b0;
    img_valid = 1'b0;

    // A fresh start reloads from idx 0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reload_ready", 64'(img_ready), 64'd1);
    dmem_word(0);
    dmem_word(1);
    img_valid = 1'b0;
    @(negedge clk);
    check("reload_nowen", 64'(wen_ext_2), 64'd0);
    check("reload_hold",  addr_ext_2,     64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
